// File: rtl/soc_system_debounce_pio.sv
// -----------------------------------------------------------------------------
// soc_system_debounce_pio
//
// Avalon-MM input PIO for board switches and buttons, WIDTH bits wide.
// Each input bit is synchronised, debounced, and edge-detected. Rising and
// falling edges can be enabled separately for every bit. Detected edges are
// latched in a write-1-to-clear capture register. A level interrupt is raised
// when a captured bit is also unmasked.
//
// Ports
//   clk        in   system clock (only clock)
//   reset      in   synchronous, active-high reset
//   address    in   word address (3 bits)
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   32-bit write data
//   readdata   out  32-bit registered read data, 1-cycle latency
//   in_port    in   WIDTH raw asynchronous inputs
//   irq        out  level interrupt = |(EDGE_CAPTURE & IRQ_MASK)
//
// Register map (word address)
//   0 DATA (RO)  1 RAW (RO)  2 IRQ_MASK  3 EDGE_CAPTURE (W1C)
//   4 RISE_EN    5 FALL_EN   6,7 read as zero
// -----------------------------------------------------------------------------
module soc_system_debounce_pio #(
    parameter int          WIDTH           = 4,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] RISE_EN_RESET   = 32'hFFFF_FFFF,
    parameter logic [31:0] FALL_EN_RESET   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign raw = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-bit debounce: a new level is accepted only after it has
    // differed from the current debounced level on DEBOUNCE_CYCLES
    // consecutive clocks. Any return to the old level restarts the count.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] db;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [CW-1:0] cnt_reg;
            logic          db_bit_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg    <= '0;
                    db_bit_reg <= 1'b0;
                end else if (raw[gi] == db_bit_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    db_bit_reg <= raw[gi];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end

            assign db[gi] = db_bit_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection and control registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] db_d_reg;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] edge_reg;
    logic [WIDTH-1:0] rise_en_reg;
    logic [WIDTH-1:0] fall_en_reg;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] wd;
    logic             wr_en;

    assign wd         = writedata[WIDTH-1:0];
    assign wr_en      = chipselect & ~write_n;
    assign edge_event = (db & ~db_d_reg & rise_en_reg) |
                        (~db & db_d_reg & fall_en_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            db_d_reg     <= '0;
            irq_mask_reg <= '0;
            edge_reg     <= '0;
            rise_en_reg  <= RISE_EN_RESET[WIDTH-1:0];
            fall_en_reg  <= FALL_EN_RESET[WIDTH-1:0];
        end else begin
            db_d_reg <= db;

            // New events are OR-ed in after the clear so a clear that
            // collides with a fresh edge never loses the event.
            if (wr_en && address == 3'd3) begin
                edge_reg <= (edge_reg & ~wd) | edge_event;
            end else begin
                edge_reg <= edge_reg | edge_event;
            end

            if (wr_en && address == 3'd2) irq_mask_reg <= wd;
            if (wr_en && address == 3'd4) rise_en_reg  <= wd;
            if (wr_en && address == 3'd5) fall_en_reg  <= wd;
        end
    end

    assign irq = |(edge_reg & irq_mask_reg);

    // ------------------------------------------------------------------
    // Read path: registered every cycle regardless of chipselect
    // ------------------------------------------------------------------
    logic [31:0] read_next;
    logic [31:0] readdata_reg;

    always_comb begin
        read_next = '0;
        case (address)
            3'd0:    read_next[WIDTH-1:0] = db;
            3'd1:    read_next[WIDTH-1:0] = raw;
            3'd2:    read_next[WIDTH-1:0] = irq_mask_reg;
            3'd3:    read_next[WIDTH-1:0] = edge_reg;
            3'd4:    read_next[WIDTH-1:0] = rise_en_reg;
            3'd5:    read_next[WIDTH-1:0] = fall_en_reg;
            default: read_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_reg <= '0;
        end else begin
            readdata_reg <= read_next;
        end
    end

    assign readdata = readdata_reg;

    // Write-data bits above WIDTH feed no register.
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};

endmodule

// File: tb/tb_soc_system_debounce_pio.sv
// -----------------------------------------------------------------------------
// tb_soc_system_debounce_pio
//
// Directed bench for soc_system_debounce_pio with WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Inputs change and outputs are sampled on the falling
// clock edge. In the comments below, "edge Ek" is the k-th rising edge after
// a stimulus change.
// -----------------------------------------------------------------------------
module tb_soc_system_debounce_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } rd_vec_t;

    rd_vec_t rst_tab  [8];
    rd_vec_t post_tab [8];

    soc_system_debounce_pio #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        cyc();
        d = readdata;
        $display("read  addr=%0d data=0x%08h", a, d);
    endtask

    initial begin
        logic [31:0] d;

        // Register values straight after reset.
        rst_tab[0] = '{3'd0, 32'h0};
        rst_tab[1] = '{3'd1, 32'h0};
        rst_tab[2] = '{3'd2, 32'h0};
        rst_tab[3] = '{3'd3, 32'h0};
        rst_tab[4] = '{3'd4, 32'hF};
        rst_tab[5] = '{3'd5, 32'h0};
        rst_tab[6] = '{3'd6, 32'h0};
        rst_tab[7] = '{3'd7, 32'h0};

        // Reads issued on edges R0..R7 after releasing a reset with all
        // inputs high. RAW is 0xF once R1 has passed; DATA becomes 0xF at R5;
        // all four rising edges are captured at R6.
        post_tab[0] = '{3'd3, 32'h0};
        post_tab[1] = '{3'd2, 32'h0};
        post_tab[2] = '{3'd4, 32'hF};
        post_tab[3] = '{3'd5, 32'h0};
        post_tab[4] = '{3'd0, 32'h0};
        post_tab[5] = '{3'd1, 32'hF};
        post_tab[6] = '{3'd3, 32'h0};
        post_tab[7] = '{3'd3, 32'hF};

        reset      = 1'b1;
        address    = 3'd4;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;

        // ---------------- reset state ----------------
        repeat (3) cyc();
        check("readdata_in_reset", readdata, 32'h0);
        check("irq_in_reset", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(rst_tab[i].addr, d);
            check($sformatf("reset_reg_addr%0d", rst_tab[i].addr), d, rst_tab[i].data);
        end
        check("irq_after_reset", {31'b0, irq}, 32'h0);

        // IRQ_MASK keeps only bits [3:0]; writes to RO addresses are ignored.
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, d);
        check("mask_upper_bits", d, 32'hF);
        wr(3'd2, 32'h0);
        wr(3'd0, 32'hF);
        rd(3'd0, d);
        check("data_ro", d, 32'h0);

        // ---------------- bit0 rising edge, latency ----------------
        address    = 3'd1;
        in_port[0] = 1'b1;
        cyc();                                        // E0
        cyc();                                        // E1
        check("raw_at_e1", readdata, 32'h0);
        cyc();                                        // E2: shows RAW after E1
        check("raw_at_e2", readdata, 32'h1);
        address = 3'd0;
        cyc();                                        // E3
        cyc();                                        // E4
        cyc();                                        // E5
        check("data_at_e5", readdata, 32'h0);
        cyc();                                        // E6: DATA after E5
        check("data_at_e6", readdata, 32'h1);
        check("irq_masked", {31'b0, irq}, 32'h0);
        address = 3'd3;
        cyc();                                        // E7: EDGE after E6
        check("edge_bit0", readdata, 32'h1);
        check("irq_before_mask", {31'b0, irq}, 32'h0);
        wr(3'd2, 32'h1);
        check("irq_after_mask", {31'b0, irq}, 32'h1);

        // ---------------- bit1 bounce ----------------
        wr(3'd3, 32'h1);
        check("irq_after_clear", {31'b0, irq}, 32'h0);
        address = 3'd0;
        // in_port[1] high for E0..E2, low for E3, high from E4 on.
        // The steady level is accepted at E9 and readable after E10.
        for (int k = 0; k < 12; k++) begin
            in_port[1] = (k == 3) ? 1'b0 : 1'b1;
            cyc();
            check($sformatf("bounce_data_e%0d", k), readdata, (k >= 10) ? 32'h3 : 32'h1);
        end
        rd(3'd3, d);
        check("bounce_edge", d, 32'h2);
        check("bounce_irq_unmasked_bit", {31'b0, irq}, 32'h0);

        // ---------------- falling-edge selection on bit2 ----------------
        wr(3'd4, 32'h0);
        wr(3'd5, 32'h4);
        wr(3'd3, 32'hF);
        in_port[2] = 1'b1;
        repeat (8) cyc();
        rd(3'd3, d);
        check("rise_disabled", d, 32'h0);
        in_port[2] = 1'b0;
        repeat (8) cyc();
        rd(3'd3, d);
        check("fall_captured", d, 32'h4);
        in_port[2] = 1'b1;
        repeat (8) cyc();
        rd(3'd3, d);
        check("rise_leaves_edge", d, 32'h4);
        rd(3'd4, d);
        check("rise_en_readback", d, 32'h0);
        rd(3'd5, d);
        check("fall_en_readback", d, 32'h4);

        // ---------------- clear colliding with a new edge ----------------
        wr(3'd4, 32'h1);
        in_port[0] = 1'b0;
        repeat (8) cyc();                              // bit0 fall not enabled
        wr(3'd3, 32'hF);
        rd(3'd3, d);
        check("edge_cleared", d, 32'h0);
        in_port[0] = 1'b1;
        repeat (6) cyc();                              // E0..E5: db set at E5
        wr(3'd3, 32'h1);                               // E6: set and clear together
        rd(3'd3, d);
        check("set_wins_over_clear", d, 32'h1);
        check("irq_set_wins", {31'b0, irq}, 32'h1);
        wr(3'd3, 32'h1);
        check("irq_after_w1c", {31'b0, irq}, 32'h0);
        rd(3'd3, d);
        check("edge_after_w1c", d, 32'h0);

        // ---------------- reset in the middle of a debounce count ----------------
        in_port[3] = 1'b1;
        repeat (4) cyc();                              // bit3 count is 2 after E3
        reset   = 1'b1;
        address = 3'd4;
        cyc();
        check("readdata_mid_reset", readdata, 32'h0);
        check("irq_mid_reset", {31'b0, irq}, 32'h0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(post_tab[i].addr, d);
            check($sformatf("post_reset_r%0d_addr%0d", i, post_tab[i].addr), d, post_tab[i].data);
        end
        check("irq_post_reset", {31'b0, irq}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
